// File: rtl/vram_pkg.sv
// Shared constants and the scan-out address helper for the VRAM arbiter.
package vram_pkg;
    localparam int H_DISPLAY      = 320;
    localparam int V_DISPLAY      = 240;
    localparam int WORDS_PER_LINE = H_DISPLAY / 4;
    localparam int FB_WORDS       = WORDS_PER_LINE * V_DISPLAY;
    localparam int ADDR_W         = 15;
    localparam int DATA_W         = 16;
    localparam int PIX_LATENCY    = 4;

    // vpos*80 + word index, built from shifts; wraps at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] scan_addr(input logic [8:0] vpos,
                                                    input logic [6:0] hword);
        logic [ADDR_W-1:0] w_v;
        w_v = ADDR_W'(vpos);
        return (w_v << 6) + (w_v << 4) + ADDR_W'(hword);
    endfunction
endpackage

// File: rtl/pixel_shifter.sv
// Captures fetched words, delays them to the pixel slot and serialises
// each 16-bit word into four 4-bit pixels, leftmost pixel first.
module pixel_shifter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_slot,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_disp,
    output logic [3:0]        o_pixel
);
    logic [PIX_LATENCY-1:1] r_vld_pipe;
    logic [DATA_W-1:0]      r_hold;
    logic [DATA_W-1:0]      r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_hold     <= '0;
            r_shift    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIX_LATENCY-2:1], i_slot};
            if (r_vld_pipe[1])
                r_hold <= i_rdata;
            // Load lands so the first nibble shows exactly PIX_LATENCY after the slot.
            if (r_vld_pipe[PIX_LATENCY-1])
                r_shift <= r_hold;
            else
                r_shift <= r_shift >> 4;
        end
    end

    assign o_pixel = i_disp ? r_shift[3:0] : 4'd0;
endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM sharing: one video fetch every fourth visible cycle,
// CPU gets all other cycles; sync/blank delayed to match the pixel stream.
module vram_scan_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        pixel,
    output logic              d_hsync,
    output logic              d_vsync,
    output logic              d_display_on
);
    logic                   r_rst_q;
    logic                   r_rd_pend;
    logic                   r_rd_oor;
    logic [ADDR_W-1:0]      r_last_addr;
    logic [PIX_LATENCY-1:0] r_hs_dly;
    logic [PIX_LATENCY-1:0] r_vs_dly;
    logic [PIX_LATENCY-1:0] r_de_dly;

    logic                   w_quiet;
    logic                   w_vslot;
    logic                   w_gnt;
    logic                   w_in_range;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;
    logic [3:0]             w_pixel;

    // Outputs stay dark during reset and the cycle right after it.
    assign w_quiet    = reset | r_rst_q;
    assign w_vslot    = display_on && (hpos[1:0] == 2'b00) && !w_quiet;
    assign w_gnt      = cpu_req && !w_vslot && !w_quiet;
    assign w_in_range = cpu_addr < ADDR_W'(FB_WORDS);

    always_comb begin
        w_addr  = r_last_addr;
        w_we    = 1'b0;
        w_wdata = '0;
        if (w_vslot) begin
            w_addr = scan_addr(vpos, hpos[8:2]);
        end else if (w_gnt) begin
            w_addr  = cpu_addr;
            w_we    = cpu_we && w_in_range;
            w_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_q     <= 1'b1;
            r_rd_pend   <= 1'b0;
            r_rd_oor    <= 1'b0;
            r_last_addr <= '0;
            r_hs_dly    <= '0;
            r_vs_dly    <= '0;
            r_de_dly    <= '0;
        end else begin
            r_rst_q     <= 1'b0;
            r_rd_pend   <= w_gnt && !cpu_we;
            r_rd_oor    <= !w_in_range;
            r_last_addr <= w_addr;
            r_hs_dly    <= {r_hs_dly[PIX_LATENCY-2:0], hsync};
            r_vs_dly    <= {r_vs_dly[PIX_LATENCY-2:0], vsync};
            r_de_dly    <= {r_de_dly[PIX_LATENCY-2:0], display_on};
        end
    end

    pixel_shifter u_shift (
        .clk     (clk),
        .reset   (reset),
        .i_slot  (w_vslot),
        .i_rdata (mem_rdata),
        .i_disp  (r_de_dly[PIX_LATENCY-1]),
        .o_pixel (w_pixel)
    );

    assign cpu_gnt      = w_gnt;
    assign mem_addr     = w_quiet ? '0 : w_addr;
    assign mem_we       = w_we;
    assign mem_wdata    = w_wdata;
    assign cpu_rvalid   = r_rd_pend && !w_quiet;
    // Out-of-range reads still return a pulse, but with zero data.
    assign cpu_rdata    = (r_rd_pend && !r_rd_oor && !w_quiet) ? mem_rdata : '0;
    assign pixel        = w_quiet ? 4'd0 : w_pixel;
    assign d_hsync      = r_hs_dly[PIX_LATENCY-1] && !w_quiet;
    assign d_vsync      = r_vs_dly[PIX_LATENCY-1] && !w_quiet;
    assign d_display_on = r_de_dly[PIX_LATENCY-1] && !w_quiet;
endmodule
